// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: op codes, FSM states,
// instruction field positions and the legal-op decode.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_XOR  = 4'd10;
  localparam logic [3:0] ALU_XNOR = 4'd11;

  localparam int REG_AW      = 4;
  localparam int OP_LSB      = 28;
  localparam int RD_LSB      = 24;
  localparam int RS1_LSB     = 20;
  localparam int RS2_LSB     = 16;
  localparam int IMM_SEL_BIT = 15;
  localparam int IMM_W       = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_t;

  function automatic logic alu_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_XNOR: alu_legal = 1'b1;
      default:                                              alu_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x WIDTH register file: two async read ports, one write path where
// writeback beats a same-cycle host preload. Entry 0 is never written.
module alu_seq_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              host_en,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data
);

  logic [WIDTH-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic wb_hit;
      logic host_hit;
      assign wb_hit   = wb_en   && (wb_addr   == REG_AW'(gi)) && (gi != 0);
      assign host_hit = host_en && (host_addr == REG_AW'(gi)) && (gi != 0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs[gi] <= '0;
        end else if (wb_hit) begin
          regs[gi] <= wb_data;
        end else if (host_hit) begin
          regs[gi] <= host_data;
        end
      end
    end
  endgenerate

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer driving a combinational 32-bit ALU: accept, issue, capture, report.
// Optional ALU_SEQ_IMM_OPERAND_EN: instr[15]=1 replaces B with zero-extended instr[14:0].
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              reg_wr_en,
  input  logic [REG_AW-1:0] reg_wr_addr,
  input  logic [WIDTH-1:0]  reg_wr_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_i,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_illegal
);

  seq_state_t        state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic              out_illegal_reg;
  logic [WIDTH-1:0]  alu_a_reg;
  logic [WIDTH-1:0]  alu_b_reg;
  logic [3:0]        alu_i_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [REG_AW-1:0] out_rd_reg;
  logic [WIDTH-1:0]  out_data_reg;

  logic [WIDTH-1:0]  rs1_data;
  logic [WIDTH-1:0]  rs2_data;
  logic [WIDTH-1:0]  operand_b;
  logic              wb_en;
  logic              op_legal;

  assign op_legal = alu_legal(alu_i_reg);
  assign wb_en    = (state_reg == ST_CAPTURE) && op_legal;

  alu_seq_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (in_instr[RS1_LSB +: REG_AW]),
    .rd_data_a (rs1_data),
    .rd_addr_b (in_instr[RS2_LSB +: REG_AW]),
    .rd_data_b (rs2_data),
    .host_en   (reg_wr_en),
    .host_addr (reg_wr_addr),
    .host_data (reg_wr_data),
    .wb_en     (wb_en),
    .wb_addr   (rd_reg),
    .wb_data   (alu_result)
  );

`ifdef ALU_SEQ_IMM_OPERAND_EN
  always_comb begin
    operand_b = rs2_data;
    if (in_instr[IMM_SEL_BIT]) begin
      operand_b = '0;
      operand_b[IMM_W-1:0] = in_instr[IMM_W-1:0];
    end
  end
`else
  logic unused_imm;
  assign unused_imm = ^in_instr[15:0];
  assign operand_b  = rs2_data;
`endif

  // Operands are read from the register file at the accept edge, so a host
  // write landing on that same edge is not visible to this instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      out_illegal_reg <= 1'b0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_i_reg       <= '0;
      rd_reg          <= '0;
      out_rd_reg      <= '0;
      out_data_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            alu_a_reg    <= rs1_data;
            alu_b_reg    <= operand_b;
            alu_i_reg    <= in_instr[OP_LSB +: 4];
            rd_reg       <= in_instr[RD_LSB +: REG_AW];
            in_ready_reg <= 1'b0;
            state_reg    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Unselected codes leave the ALU bus floating; never sample it.
          out_rd_reg      <= rd_reg;
          out_data_reg    <= op_legal ? alu_result : '0;
          out_illegal_reg <= ~op_legal;
          out_valid_reg   <= 1'b1;
          state_reg       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_i       = alu_i_reg;
  assign out_valid   = out_valid_reg;
  assign out_rd      = out_rd_reg;
  assign out_data    = out_data_reg;
  assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural ALU that drives junk
// on unselected codes, standing in for a floating result bus.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_i;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_rd;
  logic [31:0] out_data;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_i       (alu_i),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_data    (out_data),
    .out_illegal (out_illegal)
  );

  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_i)
      4'd0:  alu_result = alu_a + alu_b;
      4'd1:  alu_result = alu_a - alu_b;
      4'd8:  alu_result = alu_a & alu_b;
      4'd9:  alu_result = alu_a | alu_b;
      4'd10: alu_result = alu_a ^ alu_b;
      4'd11: alu_result = ~(alu_a ^ alu_b);
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
    reg_wr_en   = 1'b1;
    reg_wr_addr = addr;
    reg_wr_data = data;
    @(posedge clk); #1;
    reg_wr_en = 1'b0;
  endtask

  // hw_phase: 0 none, 1 host write on the accept edge, 2 host write on the capture edge
  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ed,
                        input logic eill, input int hold, input int hw_phase,
                        input logic [3:0] hw_addr, input logic [31:0] hw_data);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".ready_wait"}, in_ready, 1);
    out_ready = (hold == 0);
    in_instr  = {op, rd, rs1, rs2, imm};
    in_valid  = 1'b1;
    if (hw_phase == 1) begin
      reg_wr_en = 1'b1; reg_wr_addr = hw_addr; reg_wr_data = hw_data;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    reg_wr_en = 1'b0;
    check({tag, ".issue_i"}, alu_i, op);
    check({tag, ".issue_a"}, alu_a, ea);
    check({tag, ".issue_b"}, alu_b, eb);
    check({tag, ".issue_ready"}, in_ready, 0);
    check({tag, ".issue_valid"}, out_valid, 0);
    @(posedge clk); #1;
    if (hw_phase == 2) begin
      reg_wr_en = 1'b1; reg_wr_addr = hw_addr; reg_wr_data = hw_data;
    end
    check({tag, ".capture_valid"}, out_valid, 0);
    @(posedge clk); #1;
    reg_wr_en = 1'b0;
    check({tag, ".done_valid"}, out_valid, 1);
    check({tag, ".done_data"}, out_data, ed);
    check({tag, ".done_rd"}, out_rd, rd);
    check({tag, ".done_illegal"}, out_illegal, eill);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_instr = {4'd1, 4'd15, 4'd2, 4'd1, 16'h0000};
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, ".stall_valid"}, out_valid, 1);
        check({tag, ".stall_data"}, out_data, ed);
        check({tag, ".stall_rd"}, out_rd, rd);
        check({tag, ".stall_ready"}, in_ready, 0);
        check({tag, ".stall_alu_i"}, alu_i, op);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".consumed_valid"}, out_valid, 0);
    check({tag, ".consumed_ready"}, in_ready, 1);
    $display("txn %s op=%0d rd=%0d a=%h b=%h data=%h illegal=%0d",
             tag, op, rd, ea, eb, out_data, out_illegal);
  endtask

  logic [31:0] imm_b;
  logic [31:0] imm_d;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.alu_a", alu_a, 0);
    check("rst.alu_b", alu_b, 0);
    check("rst.alu_i", alu_i, 0);
    check("rst.out_rd", out_rd, 0);
    check("rst.out_data", out_data, 0);
    check("rst.out_illegal", out_illegal, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    host_write(4'd1, 32'd5);
    host_write(4'd2, 32'd3);
    run_op("add", 4'd0, 4'd4, 4'd1, 4'd2, 16'h0, 32'd5, 32'd3, 32'd8, 1'b0, 0, 0, 4'd0, 32'd0);
    run_op("r4_rd", 4'd9, 4'd5, 4'd4, 4'd0, 16'h0, 32'd8, 32'd0, 32'd8, 1'b0, 0, 0, 4'd0, 32'd0);

    host_write(4'd1, 32'd3);
    host_write(4'd2, 32'd5);
    run_op("sub", 4'd1, 4'd6, 4'd1, 4'd2, 16'h0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 0, 0, 4'd0, 32'd0);
    run_op("xnor", 4'd11, 4'd7, 4'd1, 4'd1, 16'h0, 32'd3, 32'd3, 32'hFFFF_FFFF, 1'b0, 0, 0, 4'd0, 32'd0);

    run_op("illegal", 4'd5, 4'd6, 4'd1, 4'd2, 16'h0, 32'd3, 32'd5, 32'd0, 1'b1, 0, 0, 4'd0, 32'd0);
    run_op("or_r6", 4'd9, 4'd8, 4'd6, 4'd0, 16'h0, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFE, 1'b0, 0, 0, 4'd0, 32'd0);

    host_write(4'd0, 32'h1234);
    run_op("wr_r0", 4'd0, 4'd0, 4'd1, 4'd2, 16'h0, 32'd3, 32'd5, 32'd8, 1'b0, 0, 0, 4'd0, 32'd0);
    run_op("rd_r0", 4'd9, 4'd9, 4'd0, 4'd0, 16'h0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0, 4'd0, 32'd0);

    run_op("host_at_accept", 4'd0, 4'd10, 4'd1, 4'd2, 16'h0, 32'd3, 32'd5, 32'd8, 1'b0, 0, 1, 4'd1, 32'd100);
    run_op("wb_vs_host", 4'd0, 4'd11, 4'd1, 4'd2, 16'h0, 32'd100, 32'd5, 32'd105, 1'b0, 0, 2, 4'd11, 32'h55);
    run_op("wb_won", 4'd9, 4'd12, 4'd11, 4'd10, 16'h0, 32'd105, 32'd8, 32'h69, 1'b0, 0, 0, 4'd0, 32'd0);

    run_op("stall_and", 4'd8, 4'd13, 4'd1, 4'd2, 16'h0, 32'd100, 32'd5, 32'd4, 1'b0, 5, 0, 4'd0, 32'd0);

    host_write(4'd1, 32'd1);
`ifdef ALU_SEQ_IMM_OPERAND_EN
    imm_b = 32'h0000_7FFF; imm_d = 32'h0000_8000;
`else
    imm_b = 32'd5; imm_d = 32'd6;
`endif
    run_op("imm", 4'd0, 4'd14, 4'd1, 4'd2, 16'hFFFF, 32'd1, imm_b, imm_d, 1'b0, 0, 0, 4'd0, 32'd0);

    // Reset while an op sits in ISSUE.
    in_instr = {4'd10, 4'd15, 4'd1, 4'd2, 16'h0};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_issue.pre_i", alu_i, 10);
    check("rst_issue.pre_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_issue.in_ready", in_ready, 1);
    check("rst_issue.out_valid", out_valid, 0);
    check("rst_issue.alu_a", alu_a, 0);
    check("rst_issue.alu_b", alu_b, 0);
    check("rst_issue.alu_i", alu_i, 0);
    check("rst_issue.out_data", out_data, 0);
    check("rst_issue.out_illegal", out_illegal, 0);
    @(posedge clk); #1;
    check("rst_issue.no_done", out_valid, 0);
    for (int k = 1; k < 16; k++) begin
      run_op($sformatf("clr_r%0d", k), 4'd9, 4'(k), 4'(k), 4'(k), 16'h0,
             32'd0, 32'd0, 32'd0, 1'b0, 0, 0, 4'd0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
